// File: rtl/mog_pkg.sv
// Shared types and constants for the mixture-of-Gaussians pipeline stages.
package mog_pkg;

  localparam int W_MSB     = 31;
  localparam int W_LSB     = 24;
  localparam int SD_MSB    = 31;
  localparam int SD_LSB    = 16;
  localparam int MOG_NUM_G = 3;
  localparam int FG_LAT    = 4;

  localparam int WGT_W  = W_MSB - W_LSB + 1;
  localparam int SD_W   = SD_MSB - SD_LSB + 1;
  localparam int PROD_W = WGT_W + SD_W;
  localparam int PRE_W  = 10;

  typedef logic [WGT_W-1:0]  wgt_t;
  typedef logic [SD_W-1:0]   sd_t;
  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [1:0]        rank_t;
  typedef logic [PRE_W-1:0]  pre_t;

  // Sum of the weights of every Gaussian ranked strictly ahead of Gaussian idx.
  function automatic pre_t rank_prefix(
    input logic [MOG_NUM_G-1:0][1:0]       ranks,
    input logic [MOG_NUM_G-1:0][WGT_W-1:0] wgts,
    input int                              idx
  );
    pre_t sum;
    sum = {PRE_W{1'b0}};
    for (int j = 0; j < MOG_NUM_G; j++) begin
      if ((j != idx) && (ranks[j] < ranks[idx])) begin
        sum = sum + {{(PRE_W-WGT_W){1'b0}}, wgts[j]};
      end else begin
        sum = sum;
      end
    end
    return sum;
  endfunction

endpackage

// File: rtl/mog_rank3.sv
// Ranks three Gaussians by w/sd using registered cross-products; latency 2.
module mog_rank3
  import mog_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic [MOG_NUM_G-1:0][WGT_W-1:0]  wgt,
  input  logic [MOG_NUM_G-1:0][SD_W-1:0]   sd,
  input  logic [MOG_NUM_G-1:0]             match,
  output logic [MOG_NUM_G-1:0][1:0]        rank,
  output logic [MOG_NUM_G-1:0][WGT_W-1:0]  wgt_q,
  output logic [MOG_NUM_G-1:0]             match_q
);

  prod_t p01_r, p10_r, p02_r, p20_r, p12_r, p21_r;
  logic [MOG_NUM_G-1:0][WGT_W-1:0] wgt_s1_r;
  logic [MOG_NUM_G-1:0]            match_s1_r;

  logic                      b01_s, b02_s, b12_s;
  logic [1:0]                cnt0_s, cnt1_s, cnt2_s;
  logic [MOG_NUM_G-1:0][1:0] rank_s;

  // S1: all ordered cross-products w_i * sd_j, plus weight/match sideband.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p01_r      <= {PROD_W{1'b0}};
      p10_r      <= {PROD_W{1'b0}};
      p02_r      <= {PROD_W{1'b0}};
      p20_r      <= {PROD_W{1'b0}};
      p12_r      <= {PROD_W{1'b0}};
      p21_r      <= {PROD_W{1'b0}};
      wgt_s1_r   <= {(MOG_NUM_G*WGT_W){1'b0}};
      match_s1_r <= {MOG_NUM_G{1'b0}};
    end else begin
      p01_r      <= prod_t'(wgt[0]) * prod_t'(sd[1]);
      p10_r      <= prod_t'(wgt[1]) * prod_t'(sd[0]);
      p02_r      <= prod_t'(wgt[0]) * prod_t'(sd[2]);
      p20_r      <= prod_t'(wgt[2]) * prod_t'(sd[0]);
      p12_r      <= prod_t'(wgt[1]) * prod_t'(sd[2]);
      p21_r      <= prod_t'(wgt[2]) * prod_t'(sd[1]);
      wgt_s1_r   <= wgt;
      match_s1_r <= match;
    end
  end

  // S2: rank_i counts the Gaussians that beat i; >= gives ties to the lower index.
  always_comb begin
    b01_s  = (p01_r >= p10_r);
    b02_s  = (p02_r >= p20_r);
    b12_s  = (p12_r >= p21_r);
    cnt0_s = {1'b0, ~b01_s} + {1'b0, ~b02_s};
    cnt1_s = {1'b0,  b01_s} + {1'b0, ~b12_s};
    cnt2_s = {1'b0,  b02_s} + {1'b0,  b12_s};
    // A cyclic outcome (only reachable with sd = 0) falls back to index order.
    if ((cnt0_s == 2'd1) && (cnt1_s == 2'd1) && (cnt2_s == 2'd1)) begin
      rank_s[0] = 2'd0;
      rank_s[1] = 2'd1;
      rank_s[2] = 2'd2;
    end else begin
      rank_s[0] = cnt0_s;
      rank_s[1] = cnt1_s;
      rank_s[2] = cnt2_s;
    end
  end

  // S2 output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rank    <= {(MOG_NUM_G*2){1'b0}};
      wgt_q   <= {(MOG_NUM_G*WGT_W){1'b0}};
      match_q <= {MOG_NUM_G{1'b0}};
    end else begin
      rank    <= rank_s;
      wgt_q   <= wgt_s1_r;
      match_q <= match_s1_r;
    end
  end

endmodule

// File: rtl/mog_fg_detect.sv
// Foreground classification: rank, background-set threshold, per-pixel fg bit
// and per-frame foreground totals.
module mog_fg_detect
  import mog_pkg::*;
#(
  parameter logic [7:0] BG_THRESH    = 8'hB3,
  parameter int         FRAME_PIXELS = 307200,
  parameter int         CNT_W        = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             window_en,
  input  logic             sof,
  input  logic [31:0]      w1_in,
  input  logic [31:0]      w2_in,
  input  logic [31:0]      w3_in,
  input  logic [31:0]      sd1_in,
  input  logic [31:0]      sd2_in,
  input  logic [31:0]      sd3_in,
  input  logic             g1_match,
  input  logic             g2_match,
  input  logic             g3_match,
  output logic             fg_valid,
  output logic             fg_pixel,
  output logic             frame_done,
  output logic [CNT_W-1:0] fg_count
);

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [MOG_NUM_G-1:0][WGT_W-1:0] wgt_s;
  logic [MOG_NUM_G-1:0][SD_W-1:0]  sd_s;
  logic [MOG_NUM_G-1:0]            match_s;
  logic [MOG_NUM_G-1:0][1:0]       rank_s;
  logic [MOG_NUM_G-1:0][WGT_W-1:0] wgt_q_s;
  logic [MOG_NUM_G-1:0]            match_q_s;
  logic                            unused_bits_s;

  logic [FG_LAT-2:0]               vld_r;
  logic [FG_LAT-2:0]               sof_r;
  pre_t [MOG_NUM_G-1:0]            pre_s;
  logic [MOG_NUM_G-1:0]            bg_s;
  logic [MOG_NUM_G-1:0]            bg_r;
  logic [MOG_NUM_G-1:0]            match_s3_r;

  logic                            fg_bit_s;
  logic                            count_s;
  logic [CNT_W-1:0]                pix_nxt_s;
  logic [CNT_W-1:0]                fg_nxt_s;
  logic [CNT_W-1:0]                pix_cnt_r;
  logic [CNT_W-1:0]                fg_cnt_r;

  assign wgt_s   = {w3_in[W_MSB:W_LSB], w2_in[W_MSB:W_LSB], w1_in[W_MSB:W_LSB]};
  assign sd_s    = {sd3_in[SD_MSB:SD_LSB], sd2_in[SD_MSB:SD_LSB], sd1_in[SD_MSB:SD_LSB]};
  assign match_s = {g3_match, g2_match, g1_match};
  assign unused_bits_s = ^{w1_in[W_LSB-1:0], w2_in[W_LSB-1:0], w3_in[W_LSB-1:0],
                           sd1_in[SD_LSB-1:0], sd2_in[SD_LSB-1:0], sd3_in[SD_LSB-1:0]};

  mog_rank3 u_rank (
    .clk     (clk),
    .rst     (rst),
    .wgt     (wgt_s),
    .sd      (sd_s),
    .match   (match_s),
    .rank    (rank_s),
    .wgt_q   (wgt_q_s),
    .match_q (match_q_s)
  );

  // Valid and sof sideband delay lines aligned with S1..S3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r <= {(FG_LAT-1){1'b0}};
      sof_r <= {(FG_LAT-1){1'b0}};
    end else begin
      vld_r <= {vld_r[FG_LAT-3:0], window_en};
      sof_r <= {sof_r[FG_LAT-3:0], window_en & sof};
    end
  end

  // S3: cumulative weight ahead of each Gaussian decides background membership.
  always_comb begin
    for (int i = 0; i < MOG_NUM_G; i++) begin
      pre_s[i] = rank_prefix(rank_s, wgt_q_s, i);
      bg_s[i]  = (pre_s[i] <= {2'b00, BG_THRESH});
    end
  end

  // S3 registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bg_r       <= {MOG_NUM_G{1'b0}};
      match_s3_r <= {MOG_NUM_G{1'b0}};
    end else begin
      bg_r       <= bg_s;
      match_s3_r <= match_q_s;
    end
  end

  // S4: first matched Gaussian in priority order; no match is foreground.
  always_comb begin
    if (match_s3_r[0]) begin
      fg_bit_s = ~bg_r[0];
    end else if (match_s3_r[1]) begin
      fg_bit_s = ~bg_r[1];
    end else if (match_s3_r[2]) begin
      fg_bit_s = ~bg_r[2];
    end else begin
      fg_bit_s = 1'b1;
    end
  end

  // Next frame-counter values; a sof pixel restarts the frame, otherwise saturate.
  always_comb begin
    count_s = sof_r[FG_LAT-2] || (pix_cnt_r < FRAME_LAST);
    if (sof_r[FG_LAT-2]) begin
      pix_nxt_s = CNT_ONE;
      fg_nxt_s  = {{(CNT_W-1){1'b0}}, fg_bit_s};
    end else begin
      pix_nxt_s = pix_cnt_r + CNT_ONE;
      fg_nxt_s  = fg_cnt_r + {{(CNT_W-1){1'b0}}, fg_bit_s};
    end
  end

  // S4 outputs and frame counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fg_valid   <= 1'b0;
      fg_pixel   <= 1'b0;
      frame_done <= 1'b0;
      fg_count   <= {CNT_W{1'b0}};
      pix_cnt_r  <= {CNT_W{1'b0}};
      fg_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      fg_valid   <= vld_r[FG_LAT-2];
      fg_pixel   <= vld_r[FG_LAT-2] & fg_bit_s;
      frame_done <= 1'b0;
      if (vld_r[FG_LAT-2] && count_s) begin
        pix_cnt_r <= pix_nxt_s;
        fg_cnt_r  <= fg_nxt_s;
        if (pix_nxt_s == FRAME_LAST) begin
          fg_count   <= fg_nxt_s;
          frame_done <= 1'b1;
        end else begin
          fg_count   <= fg_count;
        end
      end else begin
        pix_cnt_r <= pix_cnt_r;
        fg_cnt_r  <= fg_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_mog_fg_detect.sv
// Directed plus randomized bench for mog_fg_detect with a sort-based reference model.
module tb_mog_fg_detect;

  localparam int FP  = 8;
  localparam int CW  = 19;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          window_en, sof;
  logic [31:0]   w1_in, w2_in, w3_in, sd1_in, sd2_in, sd3_in;
  logic          g1_match, g2_match, g3_match;
  logic          fg_valid, fg_pixel, frame_done;
  logic [CW-1:0] fg_count;

  always #5 clk = ~clk;

  mog_fg_detect #(.BG_THRESH(8'hB3), .FRAME_PIXELS(FP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .window_en(window_en), .sof(sof),
    .w1_in(w1_in), .w2_in(w2_in), .w3_in(w3_in),
    .sd1_in(sd1_in), .sd2_in(sd2_in), .sd3_in(sd3_in),
    .g1_match(g1_match), .g2_match(g2_match), .g3_match(g3_match),
    .fg_valid(fg_valid), .fg_pixel(fg_pixel), .frame_done(frame_done),
    .fg_count(fg_count)
  );

  typedef struct {
    bit            vld;
    bit            fg;
    bit            done;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  int            done_seen = 0;
  int            m_pix = 0;
  int            m_fg = 0;
  logic [CW-1:0] m_cnt = '0;
  int            cur_w[3];
  int            cur_sd[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: stable sort by descending w/sd, then walk the order accumulating weight.
  function automatic bit ref_fg(input bit [2:0] m);
    int ord[3];
    int cum;
    int t;
    bit bg[3];
    ord = '{0, 1, 2};
    for (int a = 1; a < 3; a++) begin
      for (int b = a; b > 0; b--) begin
        if (cur_w[ord[b]] * cur_sd[ord[b-1]] > cur_w[ord[b-1]] * cur_sd[ord[b]]) begin
          t = ord[b]; ord[b] = ord[b-1]; ord[b-1] = t;
        end else break;
      end
    end
    cum = 0;
    for (int k = 0; k < 3; k++) begin
      bg[ord[k]] = (cum <= 'hB3);
      cum += cur_w[ord[k]];
    end
    if (m[0]) return !bg[0];
    if (m[1]) return !bg[1];
    if (m[2]) return !bg[2];
    return 1'b1;
  endfunction

  // One clock: drive at the falling edge, predict, check the pixel issued LAT cycles earlier.
  task automatic step(input bit en, input bit s, input int wa, input int wb, input int wc,
                      input int sa, input int sb, input int sc, input bit [2:0] m, input int hand);
    logic [31:0] r;
    exp_t e, o;
    bit counted;
    r = $urandom(); w1_in  = {wa[7:0], r[23:0]};
    r = $urandom(); w2_in  = {wb[7:0], r[23:0]};
    r = $urandom(); w3_in  = {wc[7:0], r[23:0]};
    r = $urandom(); sd1_in = {sa[15:0], r[15:0]};
    r = $urandom(); sd2_in = {sb[15:0], r[15:0]};
    r = $urandom(); sd3_in = {sc[15:0], r[15:0]};
    {g3_match, g2_match, g1_match} = m;
    window_en = en;
    sof = s;
    cur_w = '{wa, wb, wc};
    cur_sd = '{sa, sb, sc};
    e.vld = en; e.fg = 1'b0; e.done = 1'b0; counted = 1'b0;
    if (en) begin
      e.fg = (hand >= 0) ? hand[0] : ref_fg(m);
      if (s) begin
        m_pix = 1; m_fg = int'(e.fg); counted = 1'b1;
      end else if (m_pix < FP) begin
        m_pix++; m_fg += int'(e.fg); counted = 1'b1;
      end
      if (counted && m_pix == FP) begin
        m_cnt = CW'(m_fg); e.done = 1'b1;
      end
    end
    e.cnt = m_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() >= LAT) begin
      o = q.pop_front();
      chk("fg_valid", {31'd0, fg_valid}, {31'd0, o.vld});
      if (o.vld) chk("fg_pixel", {31'd0, fg_pixel}, {31'd0, o.fg});
      chk("frame_done", {31'd0, frame_done}, {31'd0, o.done});
      chk("fg_count", {13'd0, fg_count}, {13'd0, o.cnt});
    end
    if (frame_done) begin
      done_seen++;
      chk("done_with_valid", {31'd0, fg_valid}, 32'd1);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 1, 1, 1, 3'b000, -1);
  endtask

  // Case-1 weights: g1 matched is background, no match is foreground.
  task automatic pix(input bit s, input bit fg);
    step(1'b1, s, 'hC0, 'h30, 'h10, 4, 8, 16, fg ? 3'b000 : 3'b001, fg ? 1 : 0);
  endtask

  int d0;

  initial begin
    rst = 1'b1; window_en = 1'b0; sof = 1'b0;
    w1_in = '0; w2_in = '0; w3_in = '0; sd1_in = '0; sd2_in = '0; sd3_in = '0;
    g1_match = 1'b0; g2_match = 1'b0; g3_match = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_fg_valid", {31'd0, fg_valid}, 32'd0);
    chk("rst_fg_pixel", {31'd0, fg_pixel}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_fg_count", {13'd0, fg_count}, 32'd0);
    rst = 1'b0;

    // Ranking/threshold, crossing Gaussian, tie rule, multi-match priority.
    step(1'b1, 1'b1, 'hC0, 'h30, 'h10, 4, 8, 16, 3'b001, 0);
    step(1'b1, 1'b0, 'hC0, 'h30, 'h10, 4, 8, 16, 3'b010, 1);
    step(1'b1, 1'b0, 'hC0, 'h30, 'h10, 4, 8, 16, 3'b000, 1);
    step(1'b1, 1'b0, 'h80, 'h60, 'h20, 4, 4, 4, 3'b010, 0);
    step(1'b1, 1'b0, 'h80, 'h60, 'h20, 4, 4, 4, 3'b100, 1);
    step(1'b1, 1'b0, 'h40, 'h40, 'h80, 4, 4, 2, 3'b010, 1);
    step(1'b1, 1'b0, 'h40, 'h40, 'h80, 4, 4, 2, 3'b001, 0);
    step(1'b1, 1'b0, 'hC0, 'h30, 'h10, 4, 8, 16, 3'b111, 0);
    idle(LAT + 1);

    // Frame of 8 with gaps and 3 foreground pixels.
    done_seen = 0;
    pix(1'b1, 1'b1); idle(1); pix(1'b0, 1'b0); pix(1'b0, 1'b0); idle(2);
    pix(1'b0, 1'b1); pix(1'b0, 1'b0); idle(1); pix(1'b0, 1'b1); pix(1'b0, 1'b0);
    pix(1'b0, 1'b0);
    idle(LAT + 1);
    chk("frame_done_count", done_seen, 32'd1);
    chk("frame_fg_count", {13'd0, fg_count}, 32'd3);
    pix(1'b0, 1'b1); pix(1'b0, 1'b1); pix(1'b0, 1'b0);
    idle(LAT + 1);
    chk("no_second_done", done_seen, 32'd1);
    chk("extra_keep_count", {13'd0, fg_count}, 32'd3);
    pix(1'b1, 1'b1); pix(1'b0, 1'b1); pix(1'b0, 1'b0); pix(1'b0, 1'b1); pix(1'b0, 1'b1);
    pix(1'b1, 1'b0);
    idle(LAT + 1);
    chk("early_sof_no_done", done_seen, 32'd1);
    chk("early_sof_count", {13'd0, fg_count}, 32'd3);
    for (int i = 0; i < FP - 1; i++) pix(1'b0, i[0]);
    idle(LAT + 1);
    chk("second_frame_done", done_seen, 32'd2);
    chk("second_frame_count", {13'd0, fg_count}, 32'd3);

    // Randomized traffic, including small values to provoke ties.
    for (int i = 0; i < 600; i++) begin
      if (i[0]) begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
             $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(1, 65535), $urandom_range(1, 65535), $urandom_range(1, 65535),
             3'($urandom_range(0, 7)), -1);
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
             32 * $urandom_range(0, 7), 32 * $urandom_range(0, 7), 32 * $urandom_range(0, 7),
             $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4),
             3'($urandom_range(0, 7)), -1);
      end
    end
    idle(LAT + 1);

    // Asynchronous reset with three pixels of a completing frame still in flight.
    pix(1'b1, 1'b1);
    for (int i = 0; i < FP - 1; i++) pix(1'b0, 1'b1);
    d0 = done_seen;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, fg_valid}, 32'd0);
    chk("async_rst_done", {31'd0, frame_done}, 32'd0);
    q.delete();
    m_pix = 0; m_fg = 0; m_cnt = '0;
    @(negedge clk);
    idle(2);
    rst = 1'b0;
    idle(LAT + 1);
    chk("rst_no_pulse", done_seen, d0);
    chk("rst_fg_count_zero", {13'd0, fg_count}, 32'd0);
    pix(1'b1, 1'b0); pix(1'b0, 1'b1);
    for (int i = 0; i < FP - 2; i++) pix(1'b0, 1'b0);
    idle(LAT + 1);
    chk("post_rst_done", done_seen, d0 + 1);
    chk("post_rst_count", {13'd0, fg_count}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
